// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI register slave.
//   frame_w()        - total frame length (R/W bit + address + data)
//   RW_WRITE/RW_READ - encoding of the leading R/W bit
//   spi_state_t      - frame-handling FSM states
package spi_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } spi_state_t;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with edge detection.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised level (last synchroniser stage)
//   rise, fall : one-clk pulses on a synchronised 0->1 / 1->0 transition
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   dly_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      dly_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
      dly_reg  <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign q    = sync_reg[SYNC_STAGES-1];
  assign rise = q & ~dly_reg;
  assign fall = ~q & dly_reg;

endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 (MSB first) slave register file, oversampled in clk.
//   clk, rst_n      : system clock, async active-low reset
//   sclk, sdi, cs_n : raw SPI pins (asynchronous to clk)
//   sdo, sdo_oe     : read data and its output enable (sdo is 0 when not enabled)
//   regs            : flat register bus, reg k at [k*DATA_W +: DATA_W]
//   wr_valid        : one-clk pulse per committed write
//   wr_addr         : address of the last committed write
//   frame_err       : one-clk pulse when a frame is discarded
// Frame: {rw, addr[ADDR_W-1:0], data[DATA_W-1:0]}, rw = 1 for write.
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       sdi,
  input  logic                       cs_n,
  output logic                       sdo,
  output logic                       sdo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LASTA = CNT_W'(ADDR_W);     // count before last address bit
  localparam logic [CNT_W-1:0] CNT_CMDW  = CNT_W'(ADDR_W + 1); // count once command is complete

  // Synchronised pins
  logic sclk_q, sclk_rise, sclk_fall;
  logic sdi_q, sdi_rise, sdi_fall;
  logic cs_q, cs_rise, cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(sdi), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_q, sdi_rise, sdi_fall};

  // State
  spi_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [FRAME_W-1:0]  shift_reg, shift_next;
  logic [DATA_W-1:0]   rd_reg, rd_next;
  logic                sdo_reg, sdo_next;
  logic                sdo_oe_reg;
  logic                wr_valid_reg;
  logic                frame_err_reg, err_next;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic                commit;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Command as it stands on the cycle the last address bit is sampled
  logic [ADDR_W:0]     cmd_word;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                cmd_rw;
  assign cmd_word = {shift_reg[ADDR_W-1:0], sdi_q};
  assign cmd_addr = cmd_word[ADDR_W-1:0];
  assign cmd_rw   = cmd_word[ADDR_W];

  // Fields of a complete frame, used in CHECK
  logic                chk_rw;
  logic [ADDR_W-1:0]   chk_addr;
  logic [DATA_W-1:0]   chk_data;
  assign chk_rw   = shift_reg[FRAME_W-1];
  assign chk_addr = shift_reg[DATA_W +: ADDR_W];
  assign chk_data = shift_reg[DATA_W-1:0];

  logic [CNT_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]   rd_shl;
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign rd_shl  = rd_reg << 1;

  // Register file
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else if (commit && (32'(chk_addr) == gi)) begin
          reg_q <= chk_data;
        end
      end
      assign regs[gi*DATA_W +: DATA_W] = reg_q;
    end
  endgenerate

  logic [DATA_W-1:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(cmd_addr) == k) rd_word = regs[k*DATA_W +: DATA_W];
    end
  end

  // FSM next state / datapath
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    rd_next    = rd_reg;
    sdo_next   = sdo_reg;
    commit     = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        sdo_next = 1'b0;
        if (cs_fall) begin
          cnt_next   = '0;
          shift_next = '0;
          state_next = CMD;
        end
      end
      CMD: begin
        // cs_n release has priority over a coincident sclk edge
        if (cs_rise) begin
          state_next = CHECK;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[FRAME_W-2:0], sdi_q};
          cnt_next   = cnt_inc;
          if (cnt_reg == CNT_LASTA) begin
            state_next = DATA;
            if (cmd_rw == RW_READ && in_range(cmd_addr)) begin
              rd_next  = rd_word;
              sdo_next = rd_word[DATA_W-1];
            end else begin
              rd_next  = '0;
              sdo_next = 1'b0;
            end
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_next = CHECK;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[FRAME_W-2:0], sdi_q};
          cnt_next   = cnt_inc;
        end else if (sclk_fall && cnt_reg > CNT_CMDW) begin
          // The falling edge right after the last address bit keeps the
          // freshly loaded MSB on sdo so the master samples it on the
          // first data rising edge; later falls advance one bit each.
          rd_next  = rd_shl;
          sdo_next = rd_shl[DATA_W-1];
        end
      end
      CHECK: begin
        sdo_next   = 1'b0;
        state_next = IDLE;
        if (cnt_reg == CNT_FULL && chk_rw == RW_WRITE && in_range(chk_addr)) begin
          commit = 1'b1;
        end else if (chk_rw == RW_WRITE || cnt_reg != CNT_FULL) begin
          err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      rd_reg        <= '0;
      sdo_reg       <= 1'b0;
      sdo_oe_reg    <= 1'b0;
      wr_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      rd_reg        <= rd_next;
      sdo_reg       <= sdo_next;
      sdo_oe_reg    <= ~cs_q;
      wr_valid_reg  <= commit;
      frame_err_reg <= err_next;
      if (commit) wr_addr_reg <= chk_addr;
    end
  end

  assign sdo       = sdo_reg & sdo_oe_reg;
  assign sdo_oe    = sdo_oe_reg;
  assign wr_valid  = wr_valid_reg;
  assign wr_addr   = wr_addr_reg;
  assign frame_err = frame_err_reg;

endmodule
